// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB-first, parity, stop. Produces a byte with a
// one-cycle strobe and a parity/framing error flag. Sampling happens at mid-bit.
module uart_rx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int PARITY        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    output logic [7:0] dout,
    output logic       busy,
    output logic       data_strobe,
    output logic       rx_error
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge on din_s
    // START  | validating the start bit at its midpoint
    // DATA   | sampling 8 data bits at mid-bit
    // PAR    | sampling the parity bit
    // STOP   | sampling the stop bit, then strobing the byte
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_CLOCKS = BAUD_CLOCKS / 2;
    localparam int CW          = $clog2(BAUD_CLOCKS + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CLOCKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLOCKS - 1);

    state_t        state, state_next;
    logic [1:0]    sync_q;
    logic          din_s;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          baud_term;
    logic          shift_en;
    logic          par_en;
    logic          frame_done;
    logic          parity_ok;

    assign din_s     = sync_q[1];
    assign busy      = (state != S_IDLE);
    assign parity_ok = ((^shift_q) ^ par_q) == (PARITY != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    always_comb begin
        state_next = state;
        baud_term  = 1'b0;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (!din_s) state_next = S_START;
            end
            S_START: begin
                baud_term = (baud_cnt == HALF_LAST);
                if (baud_term) state_next = din_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                baud_term = (baud_cnt == BAUD_LAST);
                shift_en  = baud_term;
                if (baud_term && bit_cnt == 3'd7) state_next = S_PAR;
            end
            S_PAR: begin
                baud_term = (baud_cnt == BAUD_LAST);
                par_en    = baud_term;
                if (baud_term) state_next = S_STOP;
            end
            S_STOP: begin
                baud_term  = (baud_cnt == BAUD_LAST);
                frame_done = baud_term;
                if (baud_term) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE || state_next != state || baud_term) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // LSB-first: each new bit enters at the top and walks down
            if (shift_en) shift_q <= {din_s, shift_q[7:1]};
            if (par_en)   par_q   <= din_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout        <= '0;
            data_strobe <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            data_strobe <= frame_done;
            if (frame_done) begin
                dout     <= shift_q;
                rx_error <= !parity_ok || !din_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed/randomized bench for uart_rx: frames are built from the serial format rules
// and the received bytes, flags and timing are compared against that reference.
module tb_uart_rx;

    localparam int CLK_F  = 100_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int PAR    = 1;
    localparam int B      = CLK_F / BAUD;
    localparam int H      = B / 2;
    localparam int BT     = B * 10;
    localparam int LAT    = 2 + H + 10 * B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b1;
    logic [7:0] dout;
    logic       busy;
    logic       data_strobe;
    logic       rx_error;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    logic [8:0] got_q[$];
    longint     got_t[$];
    logic [8:0] exp_q[$];
    int         got_rd = 0;
    int         exp_rd = 0;
    int         busy_cycles = 0;
    longint     last_fall = 0;

    uart_rx #(
        .CLK_FREQUENCY(CLK_F),
        .BAUD_RATE    (BAUD),
        .PARITY       (PAR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .dout       (dout),
        .busy       (busy),
        .data_strobe(data_strobe),
        .rx_error   (rx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_strobe) begin
            got_q.push_back({rx_error, dout});
            got_t.push_back($time);
        end
        if (busy) busy_cycles <= busy_cycles + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: parity bit chosen so the 1s count matches the configured sense
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop_bit);
        logic par_bit;
        par_bit = (PAR != 0) ? ($countones(b) % 2 == 0) : ($countones(b) % 2 == 1);
        par_bit = par_bit ^ flip_par;
        exp_q.push_back({flip_par | ~stop_bit, b});
        last_fall = $time;
        din = 1'b0;
        #(BT);
        for (int i = 0; i < 8; i++) begin
            din = b[i];
            #(BT);
        end
        din = par_bit;
        #(BT);
        din = stop_bit;
        #(BT);
        din = 1'b1;
    endtask

    task automatic check_group(input string tag);
        int n_got;
        int n_exp;
        n_got = got_q.size() - got_rd;
        n_exp = exp_q.size() - exp_rd;
        chk({tag, "_count"}, n_got, n_exp);
        for (int i = 0; i < n_exp && i < n_got; i++) begin
            chk({tag, "_byte"}, got_q[got_rd + i][7:0], exp_q[exp_rd + i][7:0]);
            chk({tag, "_err"}, got_q[got_rd + i][8], exp_q[exp_rd + i][8]);
        end
        got_rd = got_q.size();
        exp_rd = exp_q.size();
    endtask

    initial begin
        int     b0;
        longint dt;
        int     busy_start;

        // reset
        @(negedge clk);
        #80;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_dout", dout, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_strobe", data_strobe, 1'b0);
        chk("reset_err", rx_error, 1'b0);
        @(negedge clk);
        busy_start = busy_cycles;
        repeat (1000) @(negedge clk);
        chk("idle_busy_cycles", busy_cycles - busy_start, 0);

        // good frame with timing and busy duration
        busy_start = busy_cycles;
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("a5_latency_valid", got_q.size() > got_rd, 1);
        if (got_q.size() > got_rd) begin
            dt = (got_t[got_rd] - last_fall) / 10;
            chk("a5_latency", (dt >= LAT - 2 && dt <= LAT + 2), 1);
        end
        chk("a5_busy_len", (busy_cycles - busy_start >= H + 10 * B - 2) &&
                           (busy_cycles - busy_start <= H + 10 * B + 2), 1);
        chk("a5_busy_end", busy, 1'b0);
        check_group("a5");

        // back-to-back random bytes
        for (int i = 0; i < 3; i++) begin
            b0 = int'($urandom_range(0, 255));
            send_frame(8'(b0), 1'b0, 1'b1);
        end
        repeat (5) @(negedge clk);
        check_group("b2b");

        // parity error then recovery
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        chk("par_err_flag", rx_error, 1'b1);
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("par_err_cleared", rx_error, 1'b0);
        check_group("parity");

        // framing error then recovery
        send_frame(8'hFF, 1'b0, 1'b0);
        repeat (2 * B) @(negedge clk);
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check_group("framing");

        // short glitch
        din = 1'b0;
        repeat (20) @(negedge clk);
        din = 1'b1;
        repeat (2 * B) @(negedge clk);
        chk("glitch_busy", busy, 1'b0);
        check_group("glitch");

        // reset during data bit 4
        din = 1'b0;
        #(BT);
        for (int i = 0; i < 4; i++) begin
            din = 1'(8'h81 >> i);
            #(BT);
        end
        din = 1'b0;
        #(BT / 2);
        chk("midrst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_strobe", data_strobe, 1'b0);
        #100;
        din = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * B) @(negedge clk);
        chk("midrst_idle", busy, 1'b0);
        check_group("midrst");
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check_group("after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
